sr_receiver: RTL

SR_RECEIVER -- requirements
Module: sr_receiver

---
 rtl/sr_pkg.sv | 24 ++
 rtl/sr_pin_sync.sv | 39 +++
 rtl/sr_receiver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Frame layout and counter sizing for the serial display link, shared by the transmitter and the receiver.
package sr_pkg;

  localparam int FRAME_W   = 16;
  localparam int DIGIT_MSB = 15;
  localparam int DOTS_MSB  = 11;
  localparam int SEG_MSB   = 7;
  localparam int FIELD4_W  = 4;
  localparam int SEG_W     = 8;

  localparam int              CNT_W   = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    SHIFTING = 1'b0,
    FULL     = 1'b1
  } sr_state_e;

  // Bit counter saturates instead of wrapping, so an over-long frame is never mistaken for a good one.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/sr_pin_sync.sv
// Synchronizer, history flop and registered rise detect for one asynchronous pin.
// level_o is the delayed synced level, aligned with rise_o; a rise is reported SYNC_STAGES+1 clk after capture.
module sr_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
    end
  end

  // History carries the level one cycle later, so data sampled here lines up with another pin's rise_o.
  assign level_o = hist_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/sr_receiver.sv
// Serial display-frame receiver: shifts dio on sclk rises, latches the frame on rclk rise (SYNC_STAGES+1 clk latency).
// Optional bit-count frame check with sticky error is enabled by defining SR_RECEIVER_FRAME_CHECK_EN.
module sr_receiver
  import sr_pkg::*;
#(
  parameter int W           = FRAME_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                dio,
  input  logic                rclk,
  output logic [W-1:0]        data_o,
  output logic [FIELD4_W-1:0] digit_o,
  output logic [FIELD4_W-1:0] dots_o,
  output logic [SEG_W-1:0]    abcdefgh_o,
  output logic                valid_o,
  output logic                frame_err_o
);

  logic sclk_lvl, sclk_rise;
  logic dio_lvl, dio_rise;
  logic rclk_lvl, rclk_rise;

  sr_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (sclk),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise)
  );

  sr_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dio (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (dio),
    .level_o (dio_lvl),
    .rise_o  (dio_rise)
  );

  sr_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (rclk),
    .level_o (rclk_lvl),
    .rise_o  (rclk_rise)
  );

  logic unused_pin_state;
  assign unused_pin_state = sclk_lvl ^ rclk_lvl ^ dio_rise;

  logic [W-1:0] shreg_q, shreg_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // The shift is folded into the latch value so a coincident last bit lands in the latched frame.
  always_comb begin
    shreg_d = shreg_q;
    if (sclk_rise) begin
      shreg_d = {shreg_q[W-2:0], dio_lvl};
    end
    data_d  = rclk_rise ? shreg_d : data_q;
    valid_d = rclk_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef SR_RECEIVER_FRAME_CHECK_EN
  localparam logic [CNT_W-1:0] W_CNT = CNT_W'(W);

  sr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic             full_eff;
  logic             err_q, err_d;

  always_comb begin
    cnt_eff  = sclk_rise ? cnt_sat_inc(cnt_q) : cnt_q;
    full_eff = (state_q == FULL) || (cnt_eff >= W_CNT);
    cnt_d    = rclk_rise ? '0 : cnt_eff;
    err_d    = err_q;
    if (rclk_rise && (!full_eff || (cnt_eff != W_CNT))) begin
      err_d = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      SHIFTING: if (cnt_eff >= W_CNT) state_d = FULL;
      FULL:     state_d = FULL;
      default:  state_d = SHIFTING;
    endcase
    if (rclk_rise) begin
      state_d = SHIFTING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHIFTING;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign frame_err_o = err_q;
`else
  assign frame_err_o = 1'b0;
`endif

  assign data_o     = data_q;
  assign digit_o    = data_q[DIGIT_MSB -: FIELD4_W];
  assign dots_o     = data_q[DOTS_MSB -: FIELD4_W];
  assign abcdefgh_o = ~data_q[SEG_MSB -: SEG_W];
  assign valid_o    = valid_q;

endmodule
